// File: rtl/conv1_pkg.sv
// Shared constants, types and the saturation helper for the first-layer
// convolution post-processing blocks.
package conv1_pkg;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int INT_W   = 34;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  localparam logic signed [INT_W-1:0] OUT_MAX_I = INT_W'(OUT_MAX);
  localparam logic signed [INT_W-1:0] OUT_MIN_I = INT_W'(OUT_MIN);

  typedef struct packed {
    logic signed [INT_W-1:0] sum;
    logic [4:0]              shift;
    logic                    relu;
  } s1_t;

  typedef struct packed {
    logic [OUT_W-1:0] pix;
    logic             clip;
  } sat_t;

  // Clamp a wide rounded value into the signed pixel range and flag the clip.
  function automatic sat_t saturate(input logic signed [INT_W-1:0] y);
    sat_t res;
    res.clip = 1'b1;
    if (y > OUT_MAX_I) begin
      res.pix = OUT_W'(OUT_MAX);
    end else if (y < OUT_MIN_I) begin
      res.pix = OUT_W'(OUT_MIN);
    end else begin
      res.pix  = y[OUT_W-1:0];
      res.clip = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_1st.sv
// Single-clock FIFO with synchronous flush; the head word is read straight
// from the storage array, so a push is visible one cycle later.
module sync_fifo_1st #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is reset too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/requant_1st.sv
// Requantisation stage after the first conv layer: bias add, optional ReLU,
// round-half-up shift, int8 saturation, then a credit-protected output FIFO.
module requant_1st
  import conv1_pkg::*;
#(
  parameter int ACC_W      = conv1_pkg::ACC_W,
  parameter int OUT_W      = conv1_pkg::OUT_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_valid_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic                    acc_ready_o,
  input  logic signed [ACC_W-1:0] bias_i,
  input  logic [4:0]              shift_i,
  input  logic                    relu_en_i,
  input  logic                    clear_i,
  output logic                    pix_valid_o,
  output logic signed [OUT_W-1:0] pix_o,
  input  logic                    pix_ready_i,
  output logic [15:0]             ovf_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  s1_t                     s1_q;
  logic                    s1_valid_q;
  logic signed [INT_W-1:0] s2_y_q;
  logic                    s2_valid_q;
  logic signed [INT_W-1:0] acc_ext;
  logic signed [INT_W-1:0] bias_ext;
  logic signed [INT_W-1:0] relu_val;
  logic signed [INT_W-1:0] rnd;
  logic signed [INT_W-1:0] y_next;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           inflight;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic [OUT_W-1:0]        fifo_head;
  logic                    accept;
  sat_t                    sat;

  assign acc_ext  = {{(INT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign bias_ext = {{(INT_W-ACC_W){bias_i[ACC_W-1]}}, bias_i};

  // Credits cover both pipeline stages, so a push always finds room.
  assign inflight    = CW'(s1_valid_q) + CW'(s2_valid_q);
  assign acc_ready_o = rst_n && !clear_i && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
  assign accept      = acc_valid_i && acc_ready_o;

  always_comb begin
    relu_val = $signed(s1_q.sum);
    if (s1_q.relu && s1_q.sum[INT_W-1]) relu_val = '0;
    rnd    = INT_W'(1) << (s1_q.shift - 5'd1);
    y_next = relu_val;
    if (s1_q.shift != 5'd0) y_next = (relu_val + rnd) >>> s1_q.shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_q.sum   <= acc_ext + bias_ext;
        s1_q.shift <= shift_i;
        s1_q.relu  <= relu_en_i;
      end
      s2_valid_q <= s1_valid_q;
      s2_y_q     <= y_next;
    end
  end

  assign sat       = saturate(s2_y_q);
  assign fifo_push = s2_valid_q && (!fifo_full || pix_ready_i);

  // Clip counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_o <= '0;
    end else if (clear_i) begin
      ovf_cnt_o <= '0;
    end else if (s2_valid_q && sat.clip && (ovf_cnt_o != 16'hFFFF)) begin
      ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
  end

  sync_fifo_1st #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (sat.pix),
    .pop_i   (pix_ready_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pix_o       = fifo_head;
  assign pix_valid_o = !fifo_empty;

endmodule

// File: tb/tb_requant_1st.sv
// Self-checking bench for requant_1st: directed scenarios plus a randomized
// run scored against an arithmetic reference model.
module tb_requant_1st;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              acc_valid_i = 1'b0;
  logic signed [31:0] acc_i = '0;
  logic              acc_ready_o;
  logic signed [31:0] bias_i = '0;
  logic [4:0]        shift_i = '0;
  logic              relu_en_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              pix_valid_o;
  logic signed [7:0] pix_o;
  logic              pix_ready_i = 1'b0;
  logic [15:0]       ovf_cnt_o;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int got_q[$];
  int exp_clips = 0;

  always #5 clk = ~clk;

  requant_1st dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_valid_i (acc_valid_i),
    .acc_i       (acc_i),
    .acc_ready_o (acc_ready_o),
    .bias_i      (bias_i),
    .shift_i     (shift_i),
    .relu_en_i   (relu_en_i),
    .clear_i     (clear_i),
    .pix_valid_o (pix_valid_o),
    .pix_o       (pix_o),
    .pix_ready_i (pix_ready_i),
    .ovf_cnt_o   (ovf_cnt_o)
  );

  // Reference: exact integer maths, floor shift after adding half an LSB.
  function automatic void model(input int a, input int b, input logic [4:0] sh,
                                input bit relu, output int pix, output bit clip);
    longint s;
    int     shv;
    s   = longint'(a) + longint'(b);
    shv = int'(sh);
    if (relu && s < 0) s = 0;
    if (shv != 0) s = (s + (longint'(1) << (shv - 1))) >>> shv;
    clip = (s > 127) || (s < -128);
    pix  = (s > 127) ? 127 : ((s < -128) ? -128 : int'(s));
  endfunction

  task automatic drive(input bit v, input int a, input int b, input logic [4:0] sh,
                       input bit relu, input bit rdy, input bit clr,
                       output bit accepted, output bit popped, output int pval);
    int  mp;
    bit  mc;
    @(negedge clk);
    acc_valid_i = v;
    acc_i       = a;
    bias_i      = b;
    shift_i     = sh;
    relu_en_i   = relu;
    pix_ready_i = rdy;
    clear_i     = clr;
    #1;
    accepted = v && acc_ready_o;
    popped   = pix_valid_o && rdy && !clr;
    pval     = int'(pix_o);
    if (accepted) begin
      model(a, b, sh, relu, mp, mc);
      exp_q.push_back(mp);
      if (mc) exp_clips++;
    end
    if (popped) got_q.push_back(pval);
    @(posedge clk);
  endtask

  task automatic do_clear();
    bit a, p;
    int v;
    drive(0, 0, 0, 5'd0, 0, 0, 1, a, p, v);
    drive(0, 0, 0, 5'd0, 0, 0, 0, a, p, v);
    exp_q.delete();
    got_q.delete();
    exp_clips = 0;
  endtask

  task automatic send_drain(input int a, input int b, input logic [4:0] sh, input bit relu,
                            output bit acc, output int val, output int lat);
    bit p, dummy;
    int pv;
    drive(1, a, b, sh, relu, 1, 0, acc, p, pv);
    val = 9999;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 5'd0, 0, 1, 0, dummy, p, pv);
      if (p) begin
        val = pv;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (acc_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=0", acc_ready_o); end
    checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_pix_valid got=%b exp=0", pix_valid_o); end
    checks++; if (pix_o !== 8'sd0) begin failures++; $display("[TB] FAIL rst_pix got=%0d exp=0", pix_o); end
    checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL rst_ovf got=%0d exp=0", ovf_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (acc_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready got=%b exp=1", acc_ready_o); end
  endtask

  task automatic test_basic();
    bit acc;
    int val, lat;
    do_clear();
    send_drain(1000, 24, 5'd4, 1, acc, val, lat);
    #1;
    checks++; if (acc !== 1'b1) begin failures++; $display("[TB] FAIL basic_accept got=%b exp=1", acc); end
    checks++; if (val !== 64) begin failures++; $display("[TB] FAIL basic_value got=%0d exp=64", val); end
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL basic_ovf got=%0d exp=0", ovf_cnt_o); end
  endtask

  task automatic test_relu_round();
    bit acc;
    int val, lat;
    do_clear();
    send_drain(-500, 0, 5'd0, 1, acc, val, lat);
    #1;
    checks++; if (val !== 0) begin failures++; $display("[TB] FAIL relu_zero got=%0d exp=0", val); end
    checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL relu_ovf got=%0d exp=0", ovf_cnt_o); end
    send_drain(-500, 0, 5'd2, 0, acc, val, lat);
    checks++; if (val !== -125) begin failures++; $display("[TB] FAIL round_neg got=%0d exp=-125", val); end
  endtask

  task automatic test_saturation();
    bit acc;
    int val, lat;
    do_clear();
    send_drain(100000, 0, 5'd0, 0, acc, val, lat);
    checks++; if (val !== 127) begin failures++; $display("[TB] FAIL sat_hi got=%0d exp=127", val); end
    send_drain(-100000, 0, 5'd0, 0, acc, val, lat);
    checks++; if (val !== -128) begin failures++; $display("[TB] FAIL sat_lo got=%0d exp=-128", val); end
    #1;
    checks++; if (ovf_cnt_o !== 16'd2) begin failures++; $display("[TB] FAIL sat_ovf got=%0d exp=2", ovf_cnt_o); end
  endtask

  task automatic test_backpressure();
    bit a, p;
    int pv, next_val, n_acc;
    do_clear();
    next_val = 1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, next_val, 0, 5'd0, 0, 0, 0, a, p, pv);
      if (a) begin next_val++; n_acc++; end
    end
    checks++; if (n_acc !== 8) begin failures++; $display("[TB] FAIL bp_accepted got=%0d exp=8", n_acc); end
    drive(1, next_val, 0, 5'd0, 0, 1, 0, a, p, pv);
    checks++; if (a !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_before_pop got=%b exp=0", a); end
    if (a) next_val++;
    drive(1, next_val, 0, 5'd0, 0, 1, 0, a, p, pv);
    checks++; if (a !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_after_pop got=%b exp=1", a); end
    if (a) next_val++;
    for (int i = 0; i < 60 && got_q.size() < 12; i++) begin
      drive(next_val <= 12, next_val, 0, 5'd0, 0, 1, 0, a, p, pv);
      if (a) next_val++;
    end
    checks++; if (got_q.size() !== 12) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      checks++; if (got_q[i] !== i + 1) begin failures++; $display("[TB] FAIL bp_order[%0d] got=%0d exp=%0d", i, got_q[i], i + 1); end
    end
  endtask

  task automatic test_clear_midstream();
    bit a, p;
    int pv, n_acc, val, lat;
    do_clear();
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 5; i++) begin
      drive(1, (n_acc == 0) ? 1000 : n_acc + 1, 0, 5'd0, 0, 0, 0, a, p, pv);
      if (a) n_acc++;
    end
    drive(0, 0, 0, 5'd0, 0, 0, 0, a, p, pv);
    #1;
    checks++; if (ovf_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL clr_ovf_before got=%0d exp=1", ovf_cnt_o); end
    drive(1, 99, 0, 5'd0, 0, 1, 1, a, p, pv);
    checks++; if (a !== 1'b0) begin failures++; $display("[TB] FAIL clr_reject got=%b exp=0", a); end
    #1;
    checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL clr_pix_valid got=%b exp=0", pix_valid_o); end
    checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL clr_ovf got=%0d exp=0", ovf_cnt_o); end
    exp_q.delete();
    got_q.delete();
    exp_clips = 0;
    send_drain(77, 0, 5'd0, 0, a, val, lat);
    checks++; if (val !== 77) begin failures++; $display("[TB] FAIL clr_first_out got=%0d exp=77", val); end
  endtask

  task automatic test_random();
    bit a, p;
    int pv, av, bv;
    logic [4:0] sh;
    do_clear();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: begin av = int'($urandom); bv = int'($urandom_range(0, 2000)) - 1000; sh = 5'($urandom_range(0, 31)); end
        1: begin av = int'($urandom_range(0, 600)) - 300; bv = int'($urandom_range(0, 60)) - 30; sh = 5'($urandom_range(0, 4)); end
        default: begin av = int'($urandom_range(0, 200000)) - 100000; bv = int'($urandom_range(0, 2000)) - 1000; sh = 5'($urandom_range(0, 12)); end
      endcase
      drive(bit'($urandom_range(0, 1)), av, bv, sh, bit'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, 0, a, p, pv);
    end
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) drive(0, 0, 0, 5'd0, 0, 1, 0, a, p, pv);
    #1;
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL rnd_pix[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ovf_cnt_o !== 16'(exp_clips)) begin failures++; $display("[TB] FAIL rnd_ovf got=%0d exp=%0d", ovf_cnt_o, exp_clips); end
  endtask

  task automatic test_reset_midstream();
    bit a, p;
    int pv;
    do_clear();
    for (int i = 0; i < 12; i++) drive(1, 1000, 0, 5'd0, 0, 0, 0, a, p, pv);
    acc_valid_i = 1'b0;
    #3;
    checks++; if (pix_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_full_valid got=%b exp=1", pix_valid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (acc_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready got=%b exp=0", acc_ready_o); end
    checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got=%b exp=0", pix_valid_o); end
    checks++; if (pix_o !== 8'sd0) begin failures++; $display("[TB] FAIL mid_rst_pix got=%0d exp=0", pix_o); end
    checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL mid_rst_ovf got=%0d exp=0", ovf_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (acc_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_release_ready got=%b exp=1", acc_ready_o); end
    exp_q.delete();
    got_q.delete();
    exp_clips = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_round();
    test_saturation();
    test_backpressure();
    test_clear_midstream();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/requant_1st.md
# requant_1st

Post-processing stage directly downstream of the first-layer convolution PE array. It takes each finished 32-bit signed accumulator result from a PE, adds a per-channel bias, applies optional ReLU, rounds and arithmetic-shifts the value, then saturates it to a signed 8-bit pixel. Results are buffered in a small FIFO and handed to the output writer over a valid/ready handshake. Upstream flow control is credit-based, so no result is ever dropped.

## Interface
Parameters:
- ACC_W, 32, accumulator result width (signed)
- OUT_W, 8, output pixel width (signed)
- FIFO_DEPTH, 8, output FIFO entries; must be ≥ 4 and a power of two

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- acc_valid_i  in  1  accumulator result present
- acc_i  in  ACC_W  signed accumulator result
- acc_ready_o  out  1  block can accept a result this cycle
- bias_i  in  ACC_W  signed bias, sampled with each accepted result
- shift_i  in  5  right-shift amount 0..31, sampled with each accepted result
- relu_en_i  in  1  ReLU enable, sampled with each accepted result
- clear_i  in  1  synchronous flush of pipeline, FIFO and counter
- pix_valid_o  out  1  FIFO head valid
- pix_o  out  OUT_W  signed output pixel (FIFO head)
- pix_ready_i  in  1  downstream accepts the head
- ovf_cnt_o  out  16  saturation event counter; sticks at 0xFFFF

## Operation
- Accept: a result is accepted when acc_valid_i && acc_ready_o at a rising edge.
- Credit: acc_ready_o = rst_n && !clear_i && (fifo_count + inflight < FIFO_DEPTH), where inflight counts occupied stages S1 and S2. A FIFO push is therefore always guaranteed room.
- S1 register:
  - sum = sext34(acc_i) + sext34(bias_i).
  - Captures shift_i and relu_en_i alongside sum.
  - Valid bit set on accept.
- S2 register:
  - r = relu ? max(sum, 0) : sum.
  - If shift == 0: y = r.
  - Otherwise: y = (r + 2^(shift-1)) >>> shift, arithmetic shift, 34-bit throughout (round half up).
- Push stage (combinational from S2):
  - y > 127 → push 127; y < -128 → push -128; otherwise push y[7:0].
  - Each clip increments ovf_cnt_o; ReLU zeroing is not counted as a clip.
- FIFO: pop on pix_valid_o && pix_ready_i.
  - Pop when empty: no effect.
  - Simultaneous push and pop: legal; count unchanged.
  - No bypass: a word pushed into an empty FIFO becomes visible on the next cycle.
- Ordering: strict FIFO order, identical to acceptance order.
- clear_i:
  - On the edge where it is sampled high: S1/S2 valid bits, FIFO pointers/count and ovf_cnt_o are all zeroed.
  - A result presented in the same cycle is not accepted (acc_ready_o is low).
  - A concurrent pop is discarded.
- Reset (async assert, any time, including mid-stream):
  - Same effect as clear_i.
  - Output values: acc_ready_o 0, pix_valid_o 0, pix_o 0, ovf_cnt_o 0.
  - acc_ready_o returns to 1 in the first cycle after rst_n is released.

## Timing
- Latency: a result accepted at edge E enters S1 at E, S2 at E+1, and is written to the FIFO at E+2. With the FIFO empty, pix_valid_o and pix_o update at edge E+2.
- Throughput: one result per cycle while pix_ready_i = 1 (FIFO_DEPTH ≥ 4 covers inflight plus one).
- Backpressure: with pix_ready_i = 0, at most FIFO_DEPTH results are accepted, then acc_ready_o stays low. acc_ready_o reasserts in the cycle after the first pop.
- Combinational paths:
  - acc_ready_o depends only on registered state, clear_i and rst_n.
  - pix_o and pix_valid_o are driven from registers/FIFO memory only.
- Sampling: bias_i, shift_i and relu_en_i only matter in accepting cycles.

## Structure
- Shared package conv1_pkg holds:
  - ACC_W and OUT_W constants
  - OUT_MAX = 127 and OUT_MIN = -128
  - the 34-bit internal width constant
- One sub-module: sync_fifo_1st, parameterised by width and depth. It provides push, pop, full, empty and count, with synchronous clear and async reset.
- S1/S2 pipeline, credit logic and ovf counter live in requant_1st.

## Test plan
- Basic arithmetic: acc = 1000, bias = 24, shift = 4, relu = 1 → pix_o = 64, seen at edge E+2; ovf_cnt_o = 0.
- ReLU and rounding:
  - acc = -500, bias = 0, relu = 1 → 0, with no ovf increment.
  - Same with relu = 0, shift = 2 → -125.
- Saturation:
  - acc = 100000, shift = 0 → 127.
  - acc = -100000, relu = 0 → -128.
  - ovf_cnt_o = 2 afterwards.
- Backpressure (pix_ready_i = 0, 12 back-to-back results with values 1..12, shift = 0):
  - Exactly 8 accepted, then acc_ready_o = 0.
  - Release ready → values 1..12 emerge in order with no loss or duplication.
- Clear mid-stream: 5 accepted, then clear_i pulsed with acc_valid_i = 1 → that result is rejected, pix_valid_o = 0 next cycle, ovf_cnt_o = 0, and the next accepted value is the first output.
- Reset mid-stream: assert rst_n low asynchronously with a full FIFO → all outputs 0 immediately; acc_ready_o = 1 in the first cycle after release.
